// File: rtl/imu_sync_pkg.sv
// rtl/imu_sync_pkg.sv - shared packet type, widths and wrap-safe due test for the IMU sync path
package imu_sync_pkg;

    localparam int TS_W  = 64;
    localparam int PKT_W = 128;

    typedef struct packed {
        logic [63:0] payload;
        logic [63:0] timestamp;
    } imu_pkt_t;

    // Due when (ref_t - ts) mod 2^64 is non-negative as a signed value
    function automatic logic ts_due(input logic [TS_W-1:0] ref_t, input logic [TS_W-1:0] ts);
        logic [TS_W-1:0] diff;
        diff = ref_t - ts;
        return ~diff[TS_W-1];
    endfunction

endpackage

// File: rtl/imu_sync_fifo.sv
// rtl/imu_sync_fifo.sv - show-ahead synchronous FIFO with registered full flag and entry count
module imu_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are don't-care after reset since pointers are cleared
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/imu_time_release_buffer.sv
// rtl/imu_time_release_buffer.sv - releases IMU packets in order once ref_time reaches their timestamp (optional TIME_RELEASE_LATE_DROP_EN)
module imu_time_release_buffer
    import imu_sync_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [63:0] MAX_LATE = 64'd1_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [127:0]                data_in,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [63:0]                 ref_time,
    output logic [127:0]                data_out,
    output logic                        valid_out,
    input  logic                        ready_out,
`ifdef TIME_RELEASE_LATE_DROP_EN
    output logic [15:0]                 late_drops,
`endif
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    logic [PKT_W-1:0] head_data;
    imu_pkt_t         head_pkt;
    logic             full;
    logic             empty;
    logic             head_due;
    logic             reg_free;
    logic             release_head;
    logic             drop_head;
    logic             pop;
    logic             push;

    assign ready_in = !full;
    assign push     = valid_in && !full;
    assign head_pkt = imu_pkt_t'(head_data);
    assign head_due = !empty && ts_due(ref_time, head_pkt.timestamp);
    assign reg_free = !valid_out || ready_out;

`ifdef TIME_RELEASE_LATE_DROP_EN
    logic [TS_W-1:0] lateness;
    logic            head_late;

    // A due head has a non-negative diff, so an unsigned compare matches the signed one
    assign lateness     = ref_time - head_pkt.timestamp;
    assign head_late    = lateness > MAX_LATE;
    assign drop_head    = head_due && head_late;
    assign release_head = head_due && !head_late && reg_free;

    // Saturating count of discarded late packets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_drops <= 16'h0000;
        end else if (drop_head && late_drops != 16'hFFFF) begin
            late_drops <= late_drops + 16'h0001;
        end
    end
`else
    logic unused_max_late;

    assign unused_max_late = ^MAX_LATE;
    assign drop_head       = 1'b0;
    assign release_head    = head_due && reg_free;
`endif

    assign pop = release_head || drop_head;

    imu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data_in),
        .pop   (pop),
        .head  (head_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Output register: load on release, clear on consume, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (release_head) begin
            valid_out <= 1'b1;
            data_out  <= head_data;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imu_time_release_buffer.sv
// tb/tb_imu_time_release_buffer.sv - directed self-checking bench for imu_time_release_buffer
module tb_imu_time_release_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] data_in;
    logic         valid_in;
    logic         ready_in;
    logic [63:0]  ref_time;
    logic [127:0] data_out;
    logic         valid_out;
    logic         ready_out;
    logic [4:0]   fifo_count;
`ifdef TIME_RELEASE_LATE_DROP_EN
    logic [15:0]  late_drops;
    localparam logic [63:0] TS2 = 64'd450;
`else
    localparam logic [63:0] TS2 = 64'd10;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    imu_time_release_buffer #(
        .DEPTH    (16),
        .MAX_LATE (64'd100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .ref_time   (ref_time),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
`ifdef TIME_RELEASE_LATE_DROP_EN
        .late_drops (late_drops),
`endif
        .fifo_count (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data_in   = '0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        ref_time  = 64'd0;
        step();
        step();
        chk("rst_valid_out", 128'(valid_out), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_fifo_count", 128'(fifo_count), 128'd0);
        chk("rst_ready_in", 128'(ready_in), 128'd1);
`ifdef TIME_RELEASE_LATE_DROP_EN
        chk("rst_late_drops", 128'(late_drops), 128'd0);
`endif
        rst_n = 1'b1;
        step();

        // Basic release
        ref_time = 64'd100;
        data_in  = {64'hA1, 64'd150};
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("basic_count1", 128'(fifo_count), 128'd1);
        chk("basic_hold100", 128'(valid_out), 128'd0);
        ref_time = 64'd149;
        step();
        chk("basic_hold149", 128'(valid_out), 128'd0);
        ref_time = 64'd150;
        step();
        chk("basic_valid", 128'(valid_out), 128'd1);
        chk("basic_data", data_out, {64'hA1, 64'd150});
        chk("basic_count0", 128'(fifo_count), 128'd0);
        step();
        chk("basic_stall_hold", 128'(valid_out), 128'd1);
        chk("basic_stall_data", data_out, {64'hA1, 64'd150});
        ready_out = 1'b1;
        step();
        chk("basic_consumed", 128'(valid_out), 128'd0);

        // Head-of-line block
        ref_time = 64'd200;
        data_in  = {64'hB1, 64'd500};
        valid_in = 1'b1;
        step();
        data_in  = {64'hB2, TS2};
        step();
        valid_in = 1'b0;
        chk("hol_count2", 128'(fifo_count), 128'd2);
        chk("hol_blocked_a", 128'(valid_out), 128'd0);
        step();
        chk("hol_blocked_b", 128'(valid_out), 128'd0);
        ref_time = 64'd500;
        step();
        chk("hol_first_valid", 128'(valid_out), 128'd1);
        chk("hol_first_data", data_out, {64'hB1, 64'd500});
        chk("hol_first_count", 128'(fifo_count), 128'd1);
        step();
        chk("hol_second_valid", 128'(valid_out), 128'd1);
        chk("hol_second_data", data_out, {64'hB2, TS2});
        chk("hol_second_count", 128'(fifo_count), 128'd0);
        step();
        chk("hol_drained", 128'(valid_out), 128'd0);

        // Backpressure to full, then drain
        ready_out = 1'b0;
        ref_time  = 64'd1000;
        for (int i = 0; i < 18; i++) begin
            data_in  = {64'(i), 64'd950 + 64'(i)};
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        chk("full_ready_in", 128'(ready_in), 128'd0);
        chk("full_count", 128'(fifo_count), 128'd16);
        chk("full_valid_out", 128'(valid_out), 128'd1);
        ready_out = 1'b1;
        for (int j = 0; j < 17; j++) begin
            chk($sformatf("drain_valid_%0d", j), 128'(valid_out), 128'd1);
            chk($sformatf("drain_data_%0d", j), data_out, {64'(j), 64'd950 + 64'(j)});
            step();
            if (j == 0) chk("full_ready_reopen", 128'(ready_in), 128'd1);
        end
        chk("drain_done_valid", 128'(valid_out), 128'd0);
        chk("drain_done_count", 128'(fifo_count), 128'd0);

        // Wrap-around
        ref_time = 64'hFFFF_FFFF_FFFF_FFF0;
        data_in  = {64'hC1, 64'h5};
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        chk("wrap_hold_pre", 128'(valid_out), 128'd0);
        ref_time = 64'd4;
        step();
        chk("wrap_hold_4", 128'(valid_out), 128'd0);
        ref_time = 64'd5;
        step();
        chk("wrap_release", 128'(valid_out), 128'd1);
        chk("wrap_data", data_out, {64'hC1, 64'h5});
        step();
        chk("wrap_consumed", 128'(valid_out), 128'd0);

        // Mid-operation asynchronous reset
        ready_out = 1'b0;
        ref_time  = 64'd2000;
        for (int i = 0; i < 6; i++) begin
            data_in  = {64'hE0 + 64'(i), 64'd1990};
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        chk("mrst_pre_count", 128'(fifo_count), 128'd5);
        chk("mrst_pre_valid", 128'(valid_out), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_async_valid", 128'(valid_out), 128'd0);
        chk("mrst_async_count", 128'(fifo_count), 128'd0);
        chk("mrst_async_ready", 128'(ready_in), 128'd1);
        step();
        rst_n     = 1'b1;
        ready_out = 1'b1;
        step();
        step();
        chk("mrst_no_stale_valid", 128'(valid_out), 128'd0);
        chk("mrst_no_stale_count", 128'(fifo_count), 128'd0);

`ifdef TIME_RELEASE_LATE_DROP_EN
        // Late drop
        ref_time = 64'd1000;
        data_in  = {64'hD1, 64'd850};
        valid_in = 1'b1;
        step();
        data_in  = {64'hD2, 64'd950};
        step();
        valid_in = 1'b0;
        chk("late_drops_one", 128'(late_drops), 128'd1);
        chk("late_no_output", 128'(valid_out), 128'd0);
        step();
        chk("late_second_valid", 128'(valid_out), 128'd1);
        chk("late_second_data", data_out, {64'hD2, 64'd950});
        chk("late_drops_still_one", 128'(late_drops), 128'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imu_time_release_buffer.md
# imu_time_release_buffer

Playout buffer downstream of the IMU time-sync stage. It accepts 128-bit IMU packets whose low 64 bits already carry an offset-adjusted timestamp. Each packet is held in order until the shared reference time reaches that timestamp, then released to the fusion core over a valid/ready interface. This block is the consumer end of the timestamp-adjust path: the sync stage writes the corrected time, and this block honours it.

## Interface
Parameters:
- DEPTH, default 16: FIFO entries; power of two, minimum 2.
- MAX_LATE, default 64'd1_000_000: lateness threshold in ref_time ticks. Used only with the late-drop feature.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous, active-low reset
- data_in  input  128  packet {payload[127:64], timestamp[63:0]}
- valid_in  input  1  upstream packet valid
- ready_in  output  1  buffer can accept; equals !full
- ref_time  input  64  free-running reference time, same clock domain
- data_out  output  128  released packet, unmodified
- valid_out  output  1  data_out holds a packet
- ready_out  input  1  downstream accepts
- fifo_count  output  $clog2(DEPTH+1)  entries stored in the FIFO, excluding the output register
- late_drops  output  16  saturating count of dropped late packets. Present only when TIME_RELEASE_LATE_DROP_EN is defined.

## Operation
- Push: the packet is written when valid_in && ready_in. ready_in depends only on the registered full flag; it does not look ahead to a same-cycle pop.
- Due test: diff = ref_time - head.timestamp, computed mod 2^64. The head is due when diff[63] == 0, i.e. when the signed difference is >= 0. This makes the test wrap-safe.
- Release: the head is popped into the output register when the FIFO is non-empty, the head is due, and the register is free. The register is free when valid_out == 0 or when (valid_out && ready_out) in the same cycle.
- Output register: data_out and valid_out hold stable while valid_out && !ready_out.
- Order is strictly FIFO. A non-due head blocks younger packets behind it, even if those packets are due.
- Simultaneous push and pop: both occur in the same cycle and fifo_count is unchanged. When full, a pop in cycle N makes ready_in high in cycle N+1.
- Packets are never modified, reordered or duplicated.
- Reset: valid_out = 0, data_out = 0, fifo_count = 0, ready_in = 1, late_drops = 0. Pointers are cleared and stored packets are discarded. Reset mid-operation takes effect immediately and asynchronously.

## Timing
- Minimum latency: a packet pushed at edge N, with a timestamp <= ref_time and an empty pipeline, shows valid_out = 1 after edge N+1. That is 2 cycles from the valid_in cycle.
- Throughput: 1 packet per cycle when all packets are due and ready_out is held high.
- The due test uses the ref_time value sampled in the cycle of the pop decision. A head becomes poppable in the first cycle in which ref_time >= timestamp.
- fifo_count and ready_in are registered and update on the edge after a push or pop.

## Configuration
- TIME_RELEASE_LATE_DROP_EN:
  - Defined: a due head with signed diff > MAX_LATE is discarded instead of released. It is popped in one cycle without touching the output register, and late_drops increments, saturating at 16'hFFFF. A discard may happen while the output register is stalled.
  - Not defined: late packets are released normally, and the late_drops port and counter do not exist.

## Structure
- Shared package imu_sync_pkg holds:
  - the packet typedef: a struct with payload[63:0] and timestamp[63:0]
  - localparams TS_W = 64 and PKT_W = 128
  - a function ts_due(ref, ts) implementing the wrap-safe compare
- Sub-module imu_sync_fifo: a synchronous FIFO with an asynchronous active-low reset. It provides push, pop, head (show-ahead), full, empty and count, parameterised on DEPTH and width.
- The top level holds the due/late logic and the output register.

## Test plan
- Basic release: with ref_time = 100, push ts = 150 → valid_out stays 0 while ref_time < 150, and rises the cycle after ref_time reaches 150; data_out equals the input.
- Head-of-line block: push ts = 500, then ts = 10, with ref_time = 200 → no output. At ref_time = 500 both packets release in order, back to back.
- Backpressure and full (DEPTH = 16): hold ready_out = 0 with all packets due and push 18 → 17 are stored (16 in the FIFO plus 1 in the register) and ready_in = 0. After releasing ready_out, 17 packets exit in order at 1 per cycle.
- Wrap-around: ref_time = 64'hFFFF_FFFF_FFFF_FFF0, push ts = 64'h5 → held until ref_time wraps to 5, then released.
- Mid-operation reset: 5 packets queued and valid_out = 1, assert rst_n = 0 for 1 cycle → valid_out = 0 and fifo_count = 0 immediately. No stale packet appears after reset.
- Late drop (macro defined, MAX_LATE = 100): ref_time = 1000, push ts = 850, then ts = 950 → the first packet is dropped with late_drops = 1; the second is released.
